// File: rtl/pc_branch_unit_if.sv
// Execute-to-fetch control-transfer bus for pc_branch_unit.
// The master is the execute stage; the slave is the PC/branch unit.
interface pc_branch_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 8
);
    logic                         stall;
    logic                         redirect_valid;
    logic [1:0]                   redirect_kind;
    logic [WIDTH-1:0]             redirect_base;
    logic [WIDTH-1:0]             offset;
    logic                         is_call;
    logic [WIDTH-1:0]             call_link;
    logic [WIDTH-1:0]             pc_out;
    logic [WIDTH-1:0]             pc_plus4;
    logic                         misalign;
    logic [$clog2(RAS_DEPTH):0]   ras_count;
    logic                         ras_empty;

    modport master (
        output stall, redirect_valid, redirect_kind, redirect_base, offset, is_call, call_link,
        input  pc_out, pc_plus4, misalign, ras_count, ras_empty
    );

    modport slave (
        input  stall, redirect_valid, redirect_kind, redirect_base, offset, is_call, call_link,
        output pc_out, pc_plus4, misalign, ras_count, ras_empty
    );
endinterface

// File: rtl/pc_branch_unit.sv
// Fetch PC register with redirect target generation, alignment check and a
// circular return-address stack. The bus interface must use the same WIDTH/RAS_DEPTH.
module pc_branch_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               RAS_DEPTH = 8,
    parameter int               ALIGN     = 2
) (
    input logic               clk,
    input logic               reset,
    pc_branch_unit_if.slave   bus
);
    localparam int               PTR_W      = $clog2(RAS_DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN) - 64'd1);

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'b00,
        KIND_JAL    = 2'b01,
        KIND_JALR   = 2'b10,
        KIND_RETURN = 2'b11
    } kind_e;

    logic [WIDTH-1:0] pc_q;
    logic             misalign_q;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] jalr_tgt;
    logic [WIDTH-1:0] tgt;
    logic [PTR_W-1:0] wr_ptr;
    logic             aligned;
    logic             do_update;
    logic             do_pop;
    logic             do_push;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sum      = bus.redirect_base + bus.offset;
        jalr_tgt = {sum[WIDTH-1:1], 1'b0};
        tgt      = sum;
        unique case (kind_e'(bus.redirect_kind))
            KIND_BRANCH, KIND_JAL: tgt = sum;
            KIND_JALR:             tgt = jalr_tgt;
            KIND_RETURN:           tgt = (ras_cnt != '0) ? ras_mem[ras_ptr] : jalr_tgt;
            default:               tgt = sum;
        endcase
        aligned   = (tgt & ALIGN_MASK) == '0;
        do_update = bus.redirect_valid && aligned;
        do_pop    = do_update && (kind_e'(bus.redirect_kind) == KIND_RETURN) && (ras_cnt != '0);
        do_push   = do_update && bus.is_call;
        // A simultaneous pop and push replaces the current top in place.
        wr_ptr    = do_pop ? ras_ptr : ras_ptr + PTR_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            ras_ptr    <= '0;
            ras_cnt    <= '0;
        end else begin
            if (bus.redirect_valid && !aligned) begin
                misalign_q <= 1'b1;
            end else if (bus.redirect_valid) begin
                pc_q       <= tgt;
                misalign_q <= 1'b0;
            end else if (bus.stall) begin
                misalign_q <= 1'b0;
            end else begin
                pc_q       <= pc_q + WIDTH'(4);
                misalign_q <= 1'b0;
            end

            if (do_push && !do_pop) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_cnt != CNT_FULL) ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                ras_ptr <= ras_ptr - PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // NOTE: stack storage has no reset; entries above ras_cnt are never read as targets.
    always_ff @(posedge clk) begin
        if (!reset && do_push) ras_mem[wr_ptr] <= bus.call_link;
    end

    assign bus.pc_out    = pc_q;
    assign bus.pc_plus4  = pc_q + WIDTH'(4);
    assign bus.misalign  = misalign_q;
    assign bus.ras_count = ras_cnt;
    assign bus.ras_empty = (ras_cnt == '0);
endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench: dut_a (ALIGN=2) and dut_b (ALIGN=1) share stimulus; the driver
// queues hand-computed expectations, a monitor checks them after each edge.
module tb_pc_branch_unit;
    localparam logic [1:0] K_BR   = 2'b00;
    localparam logic [1:0] K_JAL  = 2'b01;
    localparam logic [1:0] K_JALR = 2'b10;
    localparam logic [1:0] K_RET  = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_branch_unit_if #(.WIDTH(32), .RAS_DEPTH(8)) bus_a ();
    pc_branch_unit_if #(.WIDTH(32), .RAS_DEPTH(8)) bus_b ();

    pc_branch_unit #(.WIDTH(32), .RESET_PC(32'h0), .RAS_DEPTH(8), .ALIGN(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    pc_branch_unit #(.WIDTH(32), .RESET_PC(32'h0), .RAS_DEPTH(8), .ALIGN(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    typedef struct {
        int          idx;
        logic [31:0] pc_a;
        logic        mis_a;
        int          cnt_a;
        logic [31:0] pc_b;
        logic        mis_b;
        int          cnt_b;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_step = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic rv, input logic [1:0] kind,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic call, input logic [31:0] link);
        @(negedge clk);
        reset                = rst;
        bus_a.stall          = st;   bus_b.stall          = st;
        bus_a.redirect_valid = rv;   bus_b.redirect_valid = rv;
        bus_a.redirect_kind  = kind; bus_b.redirect_kind  = kind;
        bus_a.redirect_base  = base; bus_b.redirect_base  = base;
        bus_a.offset         = off;  bus_b.offset         = off;
        bus_a.is_call        = call; bus_b.is_call        = call;
        bus_a.call_link      = link; bus_b.call_link      = link;
    endtask

    task automatic expect_ab(input logic [31:0] pa, input logic ma, input int ca,
                             input logic [31:0] pb, input logic mb, input int cb);
        exp_t e;
        e.idx = n_step; e.pc_a = pa; e.mis_a = ma; e.cnt_a = ca;
        e.pc_b = pb; e.mis_b = mb; e.cnt_b = cb;
        q.push_back(e);
        n_step++;
    endtask

    task automatic free_run(input logic [31:0] pc, input int cnt);
        drive(1'b0, 1'b0, 1'b0, K_BR, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_ab(pc, 1'b0, cnt, pc, 1'b0, cnt);
    endtask

    task automatic stall_cycle(input logic [31:0] pc, input int cnt);
        drive(1'b0, 1'b1, 1'b0, K_BR, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_ab(pc, 1'b0, cnt, pc, 1'b0, cnt);
    endtask

    task automatic redir(input logic [1:0] kind, input logic [31:0] base, input logic [31:0] off,
                         input logic call, input logic [31:0] link,
                         input logic [31:0] pc, input int cnt);
        drive(1'b0, 1'b0, 1'b1, kind, base, off, call, link);
        expect_ab(pc, 1'b0, cnt, pc, 1'b0, cnt);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b1, K_JAL, 32'h40, 32'h0, 1'b1, 32'h44);
        expect_ab(32'h0, 1'b0, 0, 32'h0, 1'b0, 0);
    endtask

    // Monitor: registered outputs are settled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check($sformatf("a.pc[%0d]", e.idx),     bus_a.pc_out,          e.pc_a);
                check($sformatf("a.pc4[%0d]", e.idx),    bus_a.pc_plus4,        e.pc_a + 32'd4);
                check($sformatf("a.mis[%0d]", e.idx),    32'(bus_a.misalign),   32'(e.mis_a));
                check($sformatf("a.cnt[%0d]", e.idx),    32'(bus_a.ras_count),  32'(e.cnt_a));
                check($sformatf("a.empty[%0d]", e.idx),  32'(bus_a.ras_empty),  32'(e.cnt_a == 0));
                check($sformatf("b.pc[%0d]", e.idx),     bus_b.pc_out,          e.pc_b);
                check($sformatf("b.pc4[%0d]", e.idx),    bus_b.pc_plus4,        e.pc_b + 32'd4);
                check($sformatf("b.mis[%0d]", e.idx),    32'(bus_b.misalign),   32'(e.mis_b));
                check($sformatf("b.cnt[%0d]", e.idx),    32'(bus_b.ras_count),  32'(e.cnt_b));
                check($sformatf("b.empty[%0d]", e.idx),  32'(bus_b.ras_empty),  32'(e.cnt_b == 0));
            end
        end
    end

    initial begin
        reset = 1'b1;
        // Reset and free run
        do_reset();
        free_run(32'h4, 0);
        free_run(32'h8, 0);
        free_run(32'hC, 0);

        // Branches, including a negative offset
        redir(K_BR, 32'h4,   32'h4,         1'b0, 32'h0, 32'h8,  0);
        redir(K_BR, 32'h8,   32'h4,         1'b0, 32'h0, 32'hC,  0);
        redir(K_BR, 32'h100, 32'hFFFF_FFF0, 1'b0, 32'h0, 32'hF0, 0);

        // jalr to 0x202: misaligned for ALIGN=2 (PC holds), fine for ALIGN=1
        drive(1'b0, 1'b0, 1'b1, K_JALR, 32'h203, 32'h0, 1'b0, 32'h0);
        expect_ab(32'hF0, 1'b1, 0, 32'h202, 1'b0, 0);
        free_run(32'hF4, 0);
        q[q.size()-1].pc_b = 32'h206;
        do_reset();

        // RAS round trip and empty-stack fallback
        redir(K_JAL, 32'h100, 32'h20, 1'b1, 32'h104, 32'h120, 1);
        redir(K_RET, 32'h0,   32'h0,  1'b0, 32'h0,   32'h104, 0);
        redir(K_RET, 32'h300, 32'h11, 1'b0, 32'h0,   32'h310, 0);

        // Overflow: nine pushes into eight entries, then eight pops
        for (int i = 1; i <= 9; i++)
            redir(K_JAL, 32'h1000, 32'h0, 1'b1, 32'(i * 16), 32'h1000, (i > 8) ? 8 : i);
        for (int i = 0; i < 8; i++)
            redir(K_RET, 32'h0, 32'h0, 1'b0, 32'h0, 32'(32'h90 - i * 16), 7 - i);
        redir(K_RET, 32'h500, 32'h0, 1'b0, 32'h0, 32'h500, 0);

        // Return with call: target is old top, top replaced, count unchanged
        redir(K_JAL, 32'h2000, 32'h0, 1'b1, 32'hA0, 32'h2000, 1);
        redir(K_RET, 32'h0,    32'h0, 1'b1, 32'hB0, 32'hA0,   1);
        redir(K_RET, 32'h0,    32'h0, 1'b0, 32'h0,  32'hB0,   0);

        // Misaligned redirects neither pop nor push on ALIGN=2
        redir(K_JAL, 32'h400, 32'h0, 1'b1, 32'h32, 32'h400, 1);
        drive(1'b0, 1'b0, 1'b1, K_RET, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_ab(32'h400, 1'b1, 1, 32'h32, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b1, K_JAL, 32'h2002, 32'h0, 1'b1, 32'hC0);
        expect_ab(32'h400, 1'b1, 1, 32'h2002, 1'b0, 1);
        do_reset();

        // Wrap, stall, stall overridden by redirect, jalr wrap
        redir(K_BR, 32'hFFFF_FFF0, 32'hC, 1'b0, 32'h0, 32'hFFFF_FFFC, 0);
        free_run(32'h0, 0);
        stall_cycle(32'h0, 0);
        stall_cycle(32'h0, 0);
        stall_cycle(32'h0, 0);
        drive(1'b0, 1'b1, 1'b1, K_BR, 32'h40, 32'h8, 1'b0, 32'h0);
        expect_ab(32'h48, 1'b0, 0, 32'h48, 1'b0, 0);
        free_run(32'h4C, 0);
        // is_call without redirect_valid is ignored
        drive(1'b0, 1'b0, 1'b0, K_JAL, 32'h0, 32'h0, 1'b1, 32'h50);
        expect_ab(32'h50, 1'b0, 0, 32'h50, 1'b0, 0);
        redir(K_JALR, 32'hFFFF_FFFF, 32'h5, 1'b0, 32'h0, 32'h4, 0);

        // Reset with a redirect and push pending
        redir(K_JAL, 32'h80, 32'h0, 1'b1, 32'h60, 32'h80, 1);
        do_reset();
        free_run(32'h4, 0);

        @(negedge clk);
        reset = 1'b0;
        bus_a.redirect_valid = 1'b0; bus_b.redirect_valid = 1'b0;
        bus_a.stall = 1'b1;          bus_b.stall = 1'b1;
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
